// File: rtl/gray_cnt_monitor_if.sv
// Sample/result bundle between an upstream Gray counter
// source and the gray_cnt_monitor checker.
interface gray_cnt_monitor_if #(
  parameter int width = 8,
  parameter int cnt_w = 16
);
  logic [width-1:0] gray_in;
  logic             gray_vld;
  logic [width-1:0] bin_out;
  logic             out_vld;
  logic             step_up;
  logic             step_dn;
  logic             step_err;
  logic             err_sticky;
  logic [cnt_w-1:0] wrap_cnt;
  logic [cnt_w-1:0] err_cnt;

  modport master (
    output gray_in, gray_vld,
    input  bin_out, out_vld,
    input  step_up, step_dn, step_err,
    input  err_sticky, wrap_cnt, err_cnt
  );

  modport slave (
    input  gray_in, gray_vld,
    output bin_out, out_vld,
    output step_up, step_dn, step_err,
    output err_sticky, wrap_cnt, err_cnt
  );
endinterface

// File: rtl/gray_cnt_monitor.sv
// Two-stage Gray-to-binary converter that classifies each
// accepted sample against the previous one and counts events.
module gray_cnt_monitor #(
  parameter int width = 8,
  parameter int cnt_w = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  gray_cnt_monitor_if.slave    mon
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  localparam logic [width-1:0] ONE  = width'(1);
  localparam logic [width-1:0] ONES = '1;
  localparam logic [cnt_w-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic [width-1:0] s1_gray_q;
  logic             s1_vld_q;
  logic [width-1:0] prev_q, prev_d;
  logic [width-1:0] bin_q, bin_d;
  logic             vld_q, vld_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             er_q, er_d;
  logic [cnt_w-1:0] wrap_q, wrap_d;
  logic [cnt_w-1:0] errc_q, errc_d;
  logic [width-1:0] conv;
  logic [width-1:0] delta;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1_gray_q <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      s1_gray_q <= mon.gray_in;
      s1_vld_q  <= mon.gray_vld;
    end
  end

  // bin[i] is the XOR of all Gray bits at or above i
  always_comb begin
    conv = '0;
    for (int i = 0; i < width; i++) begin
      conv[i] = ^(s1_gray_q >> i);
    end
  end

  assign delta = conv - prev_q;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    bin_d   = bin_q;
    vld_d   = 1'b0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    er_d    = 1'b0;
    wrap_d  = wrap_q;
    errc_d  = errc_q;
    if (s1_vld_q) begin
      vld_d  = 1'b1;
      bin_d  = conv;
      prev_d = conv;
      if (state_q == IDLE) begin
        state_d = TRACK;
      end else begin
        // up is tested before down so width=1 only steps up
        priority case (1'b1)
          (delta == '0):  ;
          (delta == ONE):  up_d = 1'b1;
          (delta == ONES): dn_d = 1'b1;
          default:         er_d = 1'b1;
        endcase
        if (up_d && prev_q == ONES && wrap_q != CMAX) begin
          wrap_d = wrap_q + 1'b1;
        end
        if (er_d) begin
          state_d = ERROR;
          if (errc_q != CMAX) begin
            errc_d = errc_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= IDLE;
      prev_q  <= '0;
      bin_q   <= '0;
      vld_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      er_q    <= 1'b0;
      wrap_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      vld_q   <= vld_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      er_q    <= er_d;
      wrap_q  <= wrap_d;
      errc_q  <= errc_d;
    end
  end

  assign mon.bin_out    = bin_q;
  assign mon.out_vld    = vld_q;
  assign mon.step_up    = up_q;
  assign mon.step_dn    = dn_q;
  assign mon.step_err   = er_q;
  assign mon.err_sticky = (state_q == ERROR);
  assign mon.wrap_cnt   = wrap_q;
  assign mon.err_cnt    = errc_q;

endmodule

// File: doc/gray_cnt_monitor.md
GRAY_CNT_MONITOR -- requirements
Module: gray_cnt_monitor

Interface
REQ-001 Parameter: width, default 8, Gray count width; legal range 1..32.
REQ-002 Parameter: cnt_w, default 16, width of wrap and error counters; legal range 2..32.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: clr  input  1  synchronous soft clear, active-high.
REQ-006 Port: gray_in  input  width  Gray-coded count sample from the upstream Gray counter.
REQ-007 Port: gray_vld  input  1  gray_in is valid this cycle; no backpressure.
REQ-008 Port: bin_out  output  width  binary equivalent of the accepted sample.
REQ-009 Port: out_vld  output  1  one-cycle strobe; bin_out and the step flags are valid.
REQ-010 Port: step_up  output  1  sample is previous binary value +1 mod 2^width.
REQ-011 Port: step_dn  output  1  sample is previous binary value -1 mod 2^width.
REQ-012 Port: step_err  output  1  sample is neither hold, +1 nor -1 from the previous sample.
REQ-013 Port: err_sticky  output  1  high while the FSM is in ERROR.
REQ-014 Port: wrap_cnt  output  cnt_w  count of upward wraps (all-ones to zero), saturating.
REQ-015 Port: err_cnt  output  cnt_w  count of step_err events, saturating.

Function
REQ-016 Pipeline: stage 1 registers gray_in and gray_vld; stage 2 converts, classifies and registers all outputs.
REQ-017 Latency: a sample with gray_vld=1 at edge N produces out_vld=1 at edge N+2 with matching bin_out and flags.
REQ-018 Conversion: bin[width-1] = gray[width-1]; bin[i] = bin[i+1] XOR gray[i] for i < width-1.
REQ-019 FSM states: IDLE (no previous sample), TRACK, ERROR.
REQ-020 IDLE: first accepted sample sets out_vld and stores its value as previous; step flags stay 0; next state is TRACK.
REQ-021 Classification in TRACK/ERROR: delta = new_bin - prev_bin mod 2^width. Delta 0 gives hold (no flags). Delta 1 asserts step_up. Delta 2^width-1 asserts step_dn. Any other delta asserts step_err.
REQ-022 width=1: delta 1 is classified as step_up only; step_dn never asserts.
REQ-023 At most one of step_up, step_dn and step_err is high in a cycle; all three are 0 when out_vld=0.
REQ-024 Every accepted sample, including an erroneous one, replaces prev_bin.
REQ-025 step_err moves TRACK to ERROR; ERROR is left only by clr or rst; classification continues while in ERROR.
REQ-026 wrap_cnt increments on step_up with prev_bin all-ones; it saturates at 2^cnt_w-1.
REQ-027 err_cnt increments on every step_err; it saturates at 2^cnt_w-1.
REQ-028 Cycles with gray_vld=0 are ignored; gaps of any length do not affect classification.
REQ-029 clr: next state IDLE; flushes both stages; zeroes counters, outputs and prev_bin.
REQ-030 clr has priority over a sample presented in the same cycle; that sample is discarded.
REQ-031 Samples already in the pipeline when clr asserts produce no out_vld.

Reset
REQ-032 rst has priority over clr and gray_vld.
REQ-033 rst drives the FSM to IDLE and sets all outputs, counters, pipeline registers and prev_bin to 0 at the next edge.
REQ-034 rst asserted mid-stream discards in-flight samples; no out_vld follows until a new sample completes the 2-cycle latency.

Verification (width=4, cnt_w=4)
REQ-035 Bench scenario, count up: rst, then gray_in 0000, 0001, 0011 on consecutive cycles -> bin_out 0, 1, 2 at edges N+2..N+4; step_up on the 2nd and 3rd outputs; no step_err.
REQ-036 Bench scenario, wrap: 1000 then 0000 -> bin_out 15 then 0; step_up=1 and wrap_cnt=1 on the second output.
REQ-037 Bench scenario, count down: 0011 then 0001 -> bin_out 2 then 1; step_dn=1 on the second output.
REQ-038 Bench scenario, error: 0000 then 0010 (bin 3) -> step_err=1, err_cnt=1, err_sticky=1; err_sticky stays 1 through further valid steps until clr.
REQ-039 Bench scenario, clear: clr and gray_vld together, plus a sample in flight -> no out_vld; counters 0; the next sample is treated as IDLE with no flags.
REQ-040 Bench scenario, hold and saturation: the same gray_in twice gives out_vld with all flags 0; 16 error steps leave err_cnt at 15.
